addsub_nibble_sequencer: RTL and testbench

//  Multi-precision add/subtract controller that time-shares one 4-bit add/sub slice
//  (B XOR mode, ripple carry, cin = mode for the first nibble).

---
 rtl/addsub_nibble_sequencer.sv | 133 +++++++++++++
 tb/tb_addsub_nibble_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_nibble_sequencer.sv
// Multi-precision add/subtract sequencer: one 4-bit slice, LSB nibble first.
// Define ADDSUB_SEQ_OVF_EN to add the signed-overflow output ovf.
module addsub_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         mode,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         busy
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            mode_q, mode_d;
  logic            carry_q, carry_d;
  logic            carry_out_q, carry_out_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [3:0]      b_nib;
  logic [4:0]      sum5;
`ifdef ADDSUB_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    idx_d       = idx_q;
`ifdef ADDSUB_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    // The slice: B inverted in subtract mode, carry-in comes from the carry flop.
    b_nib = b_q[3:0] ^ {4{mode_q}};
    sum5  = {1'b0, a_q[3:0]} + {1'b0, b_nib} + {4'b0, carry_q};

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = RUN;
          a_d     = op_a;
          b_d     = op_b;
          mode_d  = mode;
          carry_d = mode;
          idx_d   = '0;
        end
      end
      RUN: begin
        result_d = {sum5[3:0], result_q[W-1:4]};
        carry_d  = sum5[4];
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        idx_d    = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIBBLES - 1)) begin
          state_d     = DONE;
          carry_out_d = sum5[4];
`ifdef ADDSUB_SEQ_OVF_EN
          // Carry into bit 3 recovered from the sum bit, compared with carry out of bit 3.
          ovf_d = (a_q[3] ^ b_nib[3] ^ sum5[3]) ^ sum5[4];
`endif
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      idx_q       <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      idx_q       <= idx_d;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
`ifdef ADDSUB_SEQ_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Bench for addsub_nibble_sequencer: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_addsub_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         mode = 1'b0;
  logic         res_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         start_ready, res_valid, carry_out, busy;
  logic [W-1:0] result;
`ifdef ADDSUB_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  addsub_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry_out(carry_out), .busy(busy)
`ifdef ADDSUB_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the definition of add/subtract modulo 2^W.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
    return md ? (a - b) : (a + b);
  endfunction

  function automatic logic ref_c(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
    longint ua = longint'(a);
    longint ub = longint'(b);
    return md ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
  endfunction

  function automatic logic ref_v(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
    longint sa  = longint'($signed(a));
    longint sb  = longint'($signed(b));
    longint lim = longint'(1) << (W - 1);
    longint s   = md ? (sa - sb) : (sa + sb);
    return (s >= lim) || (s < -lim);
  endfunction

  // Timing model: idle / running for NIB cycles / done, with the arithmetic precomputed.
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_c = 1'b0, p_c = 1'b0, m_v = 1'b0, p_v = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_cnt <= 0;
      m_res <= '0; m_c <= 1'b0; m_v <= 1'b0;
      p_res <= '0; p_c <= 1'b0; p_v <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin
          m_phase <= 1;
          m_cnt   <= NIB;
          p_res   <= ref_res(op_a, op_b, mode);
          p_c     <= ref_c(op_a, op_b, mode);
          p_v     <= ref_v(op_a, op_b, mode);
        end
        1: if (m_cnt == 1) begin
          m_phase <= 2;
          m_res <= p_res; m_c <= p_c; m_v <= p_v;
        end else begin
          m_cnt <= m_cnt - 1;
        end
        default: if (res_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("start_ready", start_ready, m_phase == 0);
    check("res_valid", res_valid, m_phase == 2);
    check("busy", busy, m_phase != 0);
    if (m_phase != 1) begin
      check("model_result", result, m_res);
      check("model_carry", carry_out, m_c);
`ifdef ADDSUB_SEQ_OVF_EN
      check("model_ovf", ovf, m_v);
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic md,
                        input logic [W-1:0] er, input logic ec, input logic ev, input string tag);
    int lat;
    @(negedge clk);
    op_a = a; op_b = b; mode = md; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check({tag, "_accepted"}, busy, 1'b1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, NIB);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, ec);
`ifdef ADDSUB_SEQ_OVF_EN
    check({tag, "_ovf"}, ovf, ev);
`else
    if (ev) checks += 0;
`endif
    $display("op %s: a=0x%h b=0x%h mode=%0d -> result=0x%h carry=%0d latency=%0d",
             tag, a, b, md, result, carry_out, lat);
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_back_to_idle"}, start_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int prev_acc;
    int w;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_carry", carry_out, 0);
    check("reset_start_ready", start_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_res_valid", res_valid, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add1");
    release_result("add1");
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub2");
    release_result("sub2");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap3");
    release_result("wrap3");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf3");

    // Stall in DONE while a competing request is pulsed.
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0];
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      @(posedge clk); #1;
      check("hold_result", result, 16'h7FFF);
      check("hold_start_ready", start_ready, 1'b0);
      check("hold_res_valid", res_valid, 1'b1);
      $display("hold cycle %0d: start_valid=%0d result=0x%h", i, start_valid, result);
    end
    start_valid = 1'b0;
    release_result("hold4");

    // Abort in the middle of RUN.
    @(negedge clk);
    op_a = 16'hABCD; op_b = 16'h1111; mode = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_carry", carry_out, 0);
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_start_ready", start_ready, 1);
    $display("abort: reset asserted after 2 RUN cycles, result=0x%h", result);
    @(negedge clk) rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "post_reset5");
    release_result("post_reset5");

    // Back-to-back traffic with alternating mode.
    res_ready = 1'b1;
    prev_acc = -1;
    @(negedge clk);
    op_a = 16'($urandom); op_b = 16'($urandom); mode = 1'b0; start_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      w = 0;
      while (!start_ready && w < 20) begin @(posedge clk); #1; w++; end
      check("b2b_ready_seen", start_ready, 1'b1);
      @(posedge clk); #1;
      if (prev_acc >= 0) check("b2b_period", cyc - prev_acc, NIB + 2);
      $display("b2b op %0d accepted at cycle %0d: a=0x%h b=0x%h mode=%0d",
               n, cyc, op_a, op_b, mode);
      prev_acc = cyc;
      op_a = 16'($urandom); op_b = 16'($urandom); mode = ~mode;
    end
    start_valid = 1'b0;
    repeat (NIB + 3) @(posedge clk);

    // Fully random request/response traffic, including corner operands.
    for (int i = 0; i < 400; i++) begin
      #1;
      start_valid = ($urandom_range(0, 3) != 0);
      res_ready   = ($urandom_range(0, 2) != 0);
      mode        = 1'($urandom);
      case ($urandom_range(0, 5))
        0: op_a = 16'h8000;
        1: op_a = 16'hFFFF;
        2: op_a = 16'h0000;
        default: op_a = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: op_b = 16'h7FFF;
        1: op_b = 16'h0001;
        2: op_b = 16'hFFFF;
        default: op_b = 16'($urandom);
      endcase
      @(posedge clk);
      if (res_valid && res_ready)
        $display("rand result at cycle %0d: 0x%h carry=%0d", cyc, result, carry_out);
    end
    #1;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    repeat (NIB + 3) @(posedge clk);
    #1;
    check("final_idle", start_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
